// File: rtl/pipe_pkg.sv
// Shared types and constants for the data-memory access path.
// Imported by the access controller and its helpers.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;

   // Word accesses only: low two address bits must be zero.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

endpackage

// File: rtl/dmem_access_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones.
// Counts one per clock while en is high; async active-high reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/DM loads and stores onto a req/ack data memory,
// freezing the pipeline while an access is outstanding.
module dmem_access_ctrl
   import pipe_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] write_data_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall_pipe,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              mem_fault,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   ldata_q, ldata_d;
   logic                lvalid_q, lvalid_d;
   logic                fault_q, fault_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [WAIT_W-1:0]   wait_inc;

   logic access;
   logic illegal;
   logic misaligned;
   logic launch;

   assign access     = mem_read_in ^ mem_write_in;
   assign illegal    = mem_read_in & mem_write_in;
   assign misaligned = (mem_read_in | mem_write_in)
                     & ((addr_in[1:0] & ALIGN_MASK) != 2'b00);
   assign launch     = (state_q == IDLE) & access & ~misaligned;
   assign wait_inc   = wait_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ldata_d  = ldata_q;
      lvalid_d = 1'b0;
      fault_d  = 1'b0;
      wait_d   = wait_q;

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = mem_write_in;
               addr_d  = addr_in;
               wdata_d = write_data_in;
               wait_d  = '0;
            end else if (illegal | misaligned) begin
               fault_d = 1'b1;
            end
         end
         REQ: begin
            wait_d = wait_inc;
            // An ack on the timeout cycle still counts as completion.
            if (dmem_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (!we_q) begin
                  ldata_d  = dmem_rdata;
                  lvalid_d = 1'b1;
               end
            end else if (wait_inc == WAIT_MAX) begin
               req_d   = 1'b0;
               fault_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            wait_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ldata_q  <= '0;
         lvalid_q <= 1'b0;
         fault_q  <= 1'b0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ldata_q  <= ldata_d;
         lvalid_q <= lvalid_d;
         fault_q  <= fault_d;
         wait_q   <= wait_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign load_data  = ldata_q;
   assign load_valid = lvalid_q;
   assign mem_fault  = fault_q;
   assign stall_pipe = launch | (state_q == REQ);

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (reset),
      .en    (stall_pipe),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed + randomised bench for dmem_access_ctrl against a
// transaction-level model of access outcomes and stall counts.
module tb_dmem_access_ctrl;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd, wr, ack;
   logic [31:0] addr, wdata, rdata;
   logic        req, we, stall, lvalid, fault;
   logic [31:0] daddr, dwdata, ldata;
   logic [15:0] scyc;

   logic        s_req, s_we, s_stall, s_lvalid, s_fault;
   logic [31:0] s_daddr, s_dwdata, s_ldata;
   logic [3:0]  s_scyc;

   int          checks = 0;
   int          errors = 0;
   int          stall_exp = 0;
   logic [31:0] exp_ld = '0;
   time         t_first = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(
      .DATA_W  (32),
      .TIMEOUT (TMO),
      .CNT_W   (16)
   ) dut (
      .clk           (clk),
      .reset         (rst),
      .mem_read_in   (rd),
      .mem_write_in  (wr),
      .addr_in       (addr),
      .write_data_in (wdata),
      .dmem_req      (req),
      .dmem_we       (we),
      .dmem_addr     (daddr),
      .dmem_wdata    (dwdata),
      .dmem_ack      (ack),
      .dmem_rdata    (rdata),
      .stall_pipe    (stall),
      .load_data     (ldata),
      .load_valid    (lvalid),
      .mem_fault     (fault),
      .stall_cycles  (scyc)
   );

   // Narrow counter, never-acked loads: exercises saturation quickly.
   dmem_access_ctrl #(
      .DATA_W  (32),
      .TIMEOUT (3),
      .CNT_W   (4)
   ) u_sat (
      .clk           (clk),
      .reset         (rst),
      .mem_read_in   (1'b1),
      .mem_write_in  (1'b0),
      .addr_in       (32'h0000_0010),
      .write_data_in (32'h0),
      .dmem_req      (s_req),
      .dmem_we       (s_we),
      .dmem_addr     (s_daddr),
      .dmem_wdata    (s_dwdata),
      .dmem_ack      (1'b0),
      .dmem_rdata    (32'h0),
      .stall_pipe    (s_stall),
      .load_data     (s_ldata),
      .load_valid    (s_lvalid),
      .mem_fault     (s_fault),
      .stall_cycles  (s_scyc)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access from an IDLE negedge; k = ack cycle in REQ (1-based),
   // any k outside 1..TMO means the memory never answers.
   task automatic do_access(input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdv, input int k);
      bit legal, bad, tmo;
      int n;
      rd = r; wr = w; addr = a; wdata = wd; ack = 1'b0; rdata = $urandom;
      legal = (r ^ w) && (a[1:0] == 2'b00);
      bad   = (r & w) || ((r | w) && (a[1:0] != 2'b00));
      #1 check("stall_launch", stall, legal);
      if (!legal) begin
         @(negedge clk);
         check("bad_no_req", req, 0);
         check("bad_fault", fault, bad);
         check("bad_no_lvalid", lvalid, 0);
         check("bad_scyc", scyc, stall_exp);
         rd = 1'b0; wr = 1'b0;
         #1 check("bad_no_stall", stall, 0);
         @(negedge clk);
         check("bad_fault_once", fault, 0);
         return;
      end
      tmo = !(k >= 1 && k <= TMO);
      n = tmo ? TMO : k;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (c == 1) t_first = $time;
         check("req_hi", req, 1);
         check("req_we", we, w);
         check("req_addr", daddr, a);
         check("req_wdata", dwdata, wd);
         check("req_stall", stall, 1);
         check("req_no_fault", fault, 0);
         check("req_no_lvalid", lvalid, 0);
         ack   = (c == k);
         rdata = (c == k) ? rdv : $urandom;
         addr  = $urandom;
         wdata = $urandom;
      end
      @(negedge clk);
      ack = 1'b0; addr = a; wdata = wd;
      stall_exp = stall_exp + n + 1;
      if (r && !tmo) exp_ld = rdv;
      #1;
      check("done_req_lo", req, 0);
      check("done_stall", stall, 0);
      check("done_lvalid", lvalid, r && !tmo);
      check("done_fault", fault, tmo);
      check("done_ldata", ldata, exp_ld);
      check("done_scyc", scyc, stall_exp);
      @(negedge clk);
      check("idle_no_relaunch", req, 0);
      check("idle_lvalid", lvalid, 0);
      check("idle_fault", fault, 0);
      check("idle_scyc", scyc, stall_exp);
   endtask

   initial begin
      time         t0;
      int          kind;
      logic        r;
      logic [31:0] a, wd, rdv;

      rst = 1'b1; rd = 1'b0; wr = 1'b0; ack = 1'b0;
      addr = '0; wdata = '0; rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req", req, 0);
      check("rst_we", we, 0);
      check("rst_addr", daddr, 0);
      check("rst_wdata", dwdata, 0);
      check("rst_ldata", ldata, 0);
      check("rst_lvalid", lvalid, 0);
      check("rst_fault", fault, 0);
      check("rst_stall", stall, 0);
      check("rst_scyc", scyc, 0);
      rst = 1'b0;
      @(negedge clk);

      do_access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 3);
      check("load_scyc_4", scyc, 4);
      do_access(1'b0, 1'b1, 32'h100, 32'h1234_5678, 32'h0, 1);
      do_access(1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 1);
      do_access(1'b1, 1'b1, 32'h80, 32'h5, 32'h0, 1);
      do_access(1'b1, 1'b0, 32'h200, 32'h0, 32'h1111_2222, 0);
      do_access(1'b1, 1'b0, 32'h204, 32'h0, 32'h3333_4444, TMO);

      do_access(1'b1, 1'b0, 32'h300, 32'h0, 32'hA5A5_0001, 1);
      t0 = t_first;
      do_access(1'b1, 1'b0, 32'h304, 32'h0, 32'hA5A5_0002, 1);
      check("b2b_gap", t_first - t0, 30);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         r    = $urandom_range(0, 1);
         a    = $urandom & 32'hFFFF_FFFC;
         wd   = $urandom;
         rdv  = $urandom;
         if (kind == 0) do_access(1'b1, 1'b1, a, wd, rdv, 1);
         else if (kind == 1)
            do_access(r, !r, a | $urandom_range(1, 3), wd, rdv, 1);
         else do_access(r, !r, a, wd, rdv, $urandom_range(1, 17));
      end

      rd = 1'b1; wr = 1'b0; addr = 32'h80; ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_req", req, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_req", req, 0);
      check("arst_we", we, 0);
      check("arst_addr", daddr, 0);
      check("arst_wdata", dwdata, 0);
      check("arst_ldata", ldata, 0);
      check("arst_lvalid", lvalid, 0);
      check("arst_fault", fault, 0);
      check("arst_scyc", scyc, 0);
      rd = 1'b0;
      #1 check("arst_stall", stall, 0);
      exp_ld = '0;
      stall_exp = 0;
      @(negedge clk);
      rst = 1'b0; ack = 1'b1; rdata = 32'hCAFE_F00D;
      @(negedge clk);
      ack = 1'b0;
      check("late_ack_req", req, 0);
      check("late_ack_lvalid", lvalid, 0);
      check("late_ack_ldata", ldata, exp_ld);
      check("late_ack_fault", fault, 0);
      check("late_ack_scyc", scyc, stall_exp);

      repeat (30) @(negedge clk);
      check("sat_max", s_scyc, 4'hF);
      repeat (7) @(negedge clk);
      check("sat_hold", s_scyc, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
